// File: rtl/fft_pkg.sv
// Shared types and CSR layout for the FFT input loader.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FULL,
        START,
        BUSY
    } loader_state_t;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_STATUS = 2'd1;
    localparam logic [1:0] CSR_COUNT  = 2'd2;

    localparam int CTRL_AUTO     = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_SOFT_CLR = 3;
    localparam int CTRL_GO       = 4;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_DONE    = 2;
    localparam int ST_OVERRUN = 3;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear, wraps to 1 after rollover_val; 1-cycle update.
// No backpressure: counts every cycle count_enable is high.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic [NUM_CNT_BITS-1:0] w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        if (clear) begin
            w_count_nxt = '0;
        end else if (count_enable) begin
            w_count_nxt = (r_count == rollover_val) ? ONE : r_count + ONE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign count_out = r_count;

endmodule

// File: rtl/avalon_fft_loader.sv
// Avalon-MM slave loading N_SAMPLES words into the FFT input RAM, 1-cycle write/read latency.
// Never stalls the bus: sample writes outside IDLE/LOAD are dropped and flagged as overrun.
module avalon_fft_loader
    import fft_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int N_SAMPLES = 512,
    parameter  int AV_ADDR_W = 10,
    localparam int SA_W      = $clog2(N_SAMPLES),
    localparam int CNT_W     = SA_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 av_read,
    input  logic                 av_write,
    input  logic [AV_ADDR_W-1:0] av_address,
    input  logic [DATA_W-1:0]    av_writedata,
    output logic [DATA_W-1:0]    av_readdata,
    output logic                 mem_we,
    output logic [SA_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic                 fft_start,
    input  logic                 fft_done,
    output logic                 irq
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_SAMPLES);

    loader_state_t r_state, w_state_nxt;

    logic              r_irq_en, r_auto, r_overrun, r_done;
    logic              r_mem_we;
    logic [SA_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, r_readdata, w_rd_dat;
    logic [CNT_W-1:0]  w_cnt;

    logic w_is_csr, w_smp_wr, w_ctrl_wr, w_stat_wr;
    logic w_loading, w_accept, w_drop, w_last;
    logic w_soft_req, w_soft_clr, w_go, w_n_rst, w_cnt_clr;
    logic [1:0] w_csr_off;

    assign w_is_csr   = av_address[AV_ADDR_W-1];
    assign w_csr_off  = av_address[1:0];
    assign w_smp_wr   = av_write & ~w_is_csr;
    assign w_ctrl_wr  = av_write & w_is_csr & (w_csr_off == CSR_CTRL);
    assign w_stat_wr  = av_write & w_is_csr & (w_csr_off == CSR_STATUS);
    assign w_loading  = (r_state == IDLE) | (r_state == LOAD);
    assign w_accept   = w_smp_wr & w_loading;
    assign w_drop     = w_smp_wr & ~w_loading;
    assign w_last     = w_accept & (w_cnt == LAST_CNT);
    assign w_soft_req = w_ctrl_wr & av_writedata[CTRL_SOFT_CLR];
    assign w_soft_clr = w_soft_req & (w_loading | (r_state == FULL));
    // soft_clear outranks go when both bits arrive in one write
    assign w_go       = w_ctrl_wr & av_writedata[CTRL_GO] & ~w_soft_req;
    assign w_n_rst    = ~rst;
    assign w_cnt_clr  = (r_state == START) | w_soft_clr;

    flex_counter #(
        .NUM_CNT_BITS(CNT_W)
    ) u_count (
        .clk         (clk),
        .n_rst       (w_n_rst),
        .clear       (w_cnt_clr),
        .count_enable(w_accept),
        .rollover_val(FULL_CNT),
        .count_out   (w_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_soft_clr)    w_state_nxt = IDLE;
                else if (w_accept) w_state_nxt = LOAD;
            end
            LOAD: begin
                if (w_soft_clr)  w_state_nxt = IDLE;
                else if (w_last) w_state_nxt = r_auto ? START : FULL;
            end
            FULL: begin
                if (w_soft_clr) w_state_nxt = IDLE;
                else if (w_go)  w_state_nxt = START;
            end
            START: w_state_nxt = BUSY;
            BUSY: begin
                if (fft_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_en  <= 1'b0;
            r_auto    <= 1'b1;
            r_overrun <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_irq_en <= av_writedata[CTRL_IRQ_EN];
                r_auto   <= av_writedata[CTRL_AUTO];
            end
            if (w_stat_wr && av_writedata[ST_OVERRUN]) r_overrun <= 1'b0;
            if (w_drop)                                r_overrun <= 1'b1;
            if (w_stat_wr && av_writedata[ST_DONE])    r_done    <= 1'b0;
            if ((r_state == BUSY) && fft_done)         r_done    <= 1'b1;
        end
    end

    always_comb begin
        w_rd_dat = '0;
        if (av_read && !av_write && w_is_csr) begin
            case (w_csr_off)
                CSR_CTRL: begin
                    w_rd_dat[CTRL_IRQ_EN] = r_irq_en;
                    w_rd_dat[CTRL_AUTO]   = r_auto;
                end
                CSR_STATUS: begin
                    w_rd_dat[ST_OVERRUN] = r_overrun;
                    w_rd_dat[ST_DONE]    = r_done;
                    w_rd_dat[ST_FULL]    = (r_state == FULL);
                    w_rd_dat[ST_BUSY]    = (r_state == BUSY);
                end
                CSR_COUNT: w_rd_dat[CNT_W-1:0] = w_cnt;
                default:   w_rd_dat = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_readdata  <= '0;
        end else begin
            r_mem_we   <= w_accept;
            r_readdata <= w_rd_dat;
            if (w_accept) begin
                r_mem_addr  <= av_address[SA_W-1:0];
                r_mem_wdata <= av_writedata;
            end
        end
    end

    assign av_readdata = r_readdata;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign fft_start   = (r_state == START);
    assign irq         = r_done & r_irq_en;

endmodule

// File: tb/tb_avalon_fft_loader.sv
// Scoreboard bench: frame-level model predicts RAM writes, start pulses, reads and irq.
`timescale 1ns/1ps
module tb_avalon_fft_loader;

    localparam int DW = 32;
    localparam int N  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          av_read, av_write, fft_done;
    logic [AW-1:0] av_address;
    logic [DW-1:0] av_writedata, av_readdata, mem_wdata;
    logic          mem_we, fft_start, irq;
    logic [2:0]    mem_addr;

    always #5 clk = ~clk;

    avalon_fft_loader #(.DATA_W(DW), .N_SAMPLES(N), .AV_ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst), .av_read(av_read), .av_write(av_write),
        .av_address(av_address), .av_writedata(av_writedata), .av_readdata(av_readdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fft_start(fft_start), .fft_done(fft_done), .irq(irq)
    );

    // default-parameter instance for the full 512-sample frame
    logic        b_rst, b_av_read, b_av_write, b_fft_done;
    logic [9:0]  b_av_address;
    logic [31:0] b_av_writedata, b_av_readdata, b_mem_wdata;
    logic        b_mem_we, b_fft_start, b_irq;
    logic [8:0]  b_mem_addr;

    avalon_fft_loader u_dut_big (
        .clk(clk), .rst(b_rst), .av_read(b_av_read), .av_write(b_av_write),
        .av_address(b_av_address), .av_writedata(b_av_writedata), .av_readdata(b_av_readdata),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .fft_start(b_fft_start), .fft_done(b_fft_done), .irq(b_irq)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int cy; logic [2:0] a; logic [31:0] d; } mem_exp_t;
    typedef struct { int cy; logic [31:0] v; } rd_exp_t;
    mem_exp_t mem_q[$];
    rd_exp_t  rd_q[$];
    int       start_q[$];
    logic     exp_irq, exp_irq_nxt;

    // frame model: phase 0 = collecting samples, 1 = frame waiting for go, 2 = FFT running
    int m_phase, m_cnt;
    bit m_ovr, m_done, m_auto, m_irqen;

    always @(posedge clk or posedge rst)
        if (rst) exp_irq <= 1'b0;
        else     exp_irq <= exp_irq_nxt;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (mem_q.size() == 0) chk("mem_we_unexpected", mem_we, 0);
                else begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    chk("mem_cycle", cyc, e.cy);
                    chk("mem_addr", mem_addr, e.a);
                    chk("mem_wdata", mem_wdata, e.d);
                end
            end else if (mem_q.size() > 0 && mem_q[0].cy <= cyc) begin
                chk("mem_we_missing", mem_we, 1);
                void'(mem_q.pop_front());
            end
            if (rd_q.size() > 0 && rd_q[0].cy <= cyc) begin
                rd_exp_t r;
                r = rd_q.pop_front();
                chk("read_cycle", cyc, r.cy);
                chk("readdata", av_readdata, r.v);
            end else begin
                chk("readdata_idle", av_readdata, 0);
            end
            if (fft_start) begin
                if (start_q.size() == 0) chk("fft_start_unexpected", fft_start, 0);
                else chk("fft_start_cycle", cyc, start_q.pop_front());
            end else if (start_q.size() > 0 && start_q[0] <= cyc) begin
                chk("fft_start_missing", fft_start, 1);
                void'(start_q.pop_front());
            end
            chk("irq", irq, exp_irq);
        end
    end

    task automatic idle_drv();
        av_read = 0; av_write = 0; fft_done = 0; av_address = '0; av_writedata = '0;
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        idle_drv();
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_ovr = 0; m_done = 0; m_auto = 1; m_irqen = 0;
        exp_irq_nxt = 0;
    endtask

    // the cycle after a start is left idle so every later op sees the FFT as running
    task automatic fire_start();
        start_q.push_back(cyc + 1);
        m_phase = 2;
        m_cnt = 0;
        exp_irq_nxt = m_done & m_irqen;
        begin_cycle();
    endtask

    task automatic sample_wr(input logic [2:0] a, input logic [31:0] d);
        begin_cycle();
        av_write = 1; av_address = {1'b0, a}; av_writedata = d;
        if (m_phase == 0) begin
            mem_q.push_back('{cyc + 1, a, d});
            m_cnt++;
            if (m_cnt == N) begin
                if (m_auto) fire_start();
                else m_phase = 1;
            end
        end else begin
            m_ovr = 1;
        end
        exp_irq_nxt = m_done & m_irqen;
    endtask

    task automatic csr_wr(input logic [1:0] off, input logic [31:0] d, input bit rd);
        bit go;
        begin_cycle();
        av_write = 1; av_read = rd; av_address = {2'b10, off}; av_writedata = d;
        go = 0;
        if (off == 0) begin
            m_irqen = d[2];
            m_auto  = d[1];
            if (d[3]) begin
                if (m_phase != 2) begin m_phase = 0; m_cnt = 0; end
            end else if (d[4] && m_phase == 1) begin
                go = 1;
            end
        end else if (off == 1) begin
            if (d[3]) m_ovr = 0;
            if (d[2]) m_done = 0;
        end
        exp_irq_nxt = m_done & m_irqen;
        if (go) fire_start();
    endtask

    task automatic csr_rd(input logic [1:0] off);
        logic [31:0] v;
        begin_cycle();
        av_read = 1; av_address = {2'b10, off};
        case (off)
            2'd0:    v = (32'(m_irqen) << 2) | (32'(m_auto) << 1);
            2'd1:    v = (32'(m_ovr) << 3) | (32'(m_done) << 2) |
                         (32'(m_phase == 1) << 1) | 32'(m_phase == 2);
            2'd2:    v = 32'(m_cnt);
            default: v = 0;
        endcase
        rd_q.push_back('{cyc + 1, v});
    endtask

    task automatic smp_rd(input logic [2:0] a);
        begin_cycle();
        av_read = 1; av_address = {1'b0, a};
        rd_q.push_back('{cyc + 1, 32'd0});
    endtask

    task automatic done_pulse();
        begin_cycle();
        fft_done = 1;
        if (m_phase == 2) begin m_done = 1; m_phase = 0; m_cnt = 0; end
        exp_irq_nxt = m_done & m_irqen;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) sample_wr(3'(i), $urandom);
    endtask

    task automatic pulse_reset();
        begin_cycle();
        rst = 1;
        mem_q.delete(); rd_q.delete(); start_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_fft_start", fft_start, 0);
        chk("rst_irq", irq, 0);
        chk("rst_readdata", av_readdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 0;
    endtask

    int b_we_cnt = 0;
    int b_start_cnt = 0;
    always @(negedge clk) begin
        if (b_mem_we) b_we_cnt++;
        if (b_fft_start) b_start_cnt++;
    end

    initial begin
        rst = 1; b_rst = 1;
        idle_drv();
        b_av_read = 0; b_av_write = 0; b_fft_done = 0; b_av_address = '0; b_av_writedata = '0;
        model_reset();
        pulse_reset();

        // reset values of CTRL and STATUS
        csr_rd(0);
        csr_rd(1);
        // full frame with auto start
        for (int i = 0; i < N; i++) sample_wr(3'(i), 32'hA0 + 32'(i));
        csr_rd(1);
        // overrun while busy, then done and W1C
        sample_wr(3'd3, 32'hDEAD);
        done_pulse();
        csr_rd(1);
        csr_wr(1, 32'hC, 0);
        csr_rd(1);
        // manual start through go
        csr_wr(0, 32'h0, 0);
        load(N);
        csr_rd(1);
        csr_rd(2);
        sample_wr(3'd1, 32'h55);
        csr_wr(0, 32'h10, 0);
        done_pulse();
        csr_wr(1, 32'hC, 0);
        csr_wr(0, 32'h2, 0);
        // soft clear mid-load, reset mid-load
        load(5);
        csr_rd(2);
        csr_wr(0, 32'hA, 0);
        csr_rd(2);
        csr_rd(1);
        load(5);
        pulse_reset();
        load(3);
        csr_rd(2);
        load(5);
        // ignored fft_done/go, read+write collision, sample-window read
        done_pulse();
        done_pulse();
        csr_wr(0, 32'h12, 0);
        csr_wr(0, 32'h6, 1);
        smp_rd(3'd2);
        load(N);
        done_pulse();
        csr_rd(1);
        csr_wr(1, 32'h4, 0);

        // randomized traffic
        for (int it = 0; it < 600; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 50) sample_wr(3'($urandom), $urandom);
            else if (r < 60) csr_rd(2'($urandom));
            else if (r < 64) smp_rd(3'($urandom));
            else if (r < 72) begin
                logic [31:0] d;
                d = $urandom;
                d[3] = ($urandom_range(0, 5) == 0);
                csr_wr(0, d, 1'($urandom_range(0, 3) == 0));
            end
            else if (r < 78) csr_wr(1, $urandom, 0);
            else if (r < 81) csr_wr(2'($urandom_range(2, 3)), $urandom, 0);
            else if (r < 92) begin
                if (m_phase == 2 || r < 84) done_pulse();
                else begin_cycle();
            end
            else begin_cycle();
        end
        repeat (3) begin_cycle();
        chk("mem_q_drained", mem_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("start_q_drained", start_q.size(), 0);

        // 512-sample frame on the default-parameter instance
        @(posedge clk);
        #1 b_rst = 0;
        for (int i = 0; i < 512; i++) begin
            @(posedge clk);
            #1;
            if (i == 511) chk("big_no_early_start", b_start_cnt, 0);
            b_av_write = 1; b_av_address = 10'(i); b_av_writedata = 32'h5A5A0000 ^ 32'(i);
        end
        @(posedge clk);
        #1 b_av_write = 0;
        @(negedge clk);
        #1;
        chk("big_fft_start", b_fft_start, 1);
        chk("big_we_count", b_we_cnt, 512);
        chk("big_last_addr", b_mem_addr, 511);
        chk("big_last_data", b_mem_wdata, 32'h5A5A01FF);
        @(posedge clk);
        #1;
        b_av_write = 1; b_av_address = 10'h200; b_av_writedata = 32'h6;
        @(posedge clk);
        #1;
        b_av_write = 0; b_fft_done = 1;
        @(posedge clk);
        #1;
        b_fft_done = 0; b_av_read = 1; b_av_address = 10'h201;
        @(posedge clk);
        #1;
        b_av_read = 0;
        chk("big_irq", b_irq, 1);
        chk("big_status", b_av_readdata, 32'h4);
        chk("big_start_count", b_start_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
